// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of a single-port
// synchronous memory with one clock of read latency.
// Optional feature macro MEM_ARBITER_CLEAR_EN: when defined, the controller
// zero-fills the whole memory after every reset before accepting requests.
module mem_arbiter #(
  parameter int ADDR       = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic                  req_b,
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic [ADDR-1:0]       addr_a,
  input  logic [ADDR-1:0]       addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  rvalid_a,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  busy,
  output logic                  mem_r_w,
  output logic [ADDR-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  // prio_b = 1 means B wins a tie (A was granted most recently)
  logic prio_b;
  logic rd_pend_a;
  logic rd_pend_b;
  logic run;

`ifdef MEM_ARBITER_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state;
  state_t          state_next;
  logic [ADDR-1:0] clr_cnt;

  // State register and clear address counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Leave CLEAR once the last address has been written
  always_comb begin
    state_next = state;
    if ((state == CLEAR) && (clr_cnt == {ADDR{1'b1}})) state_next = RUN;
  end

  assign run  = (state == RUN);
  assign busy = (state == CLEAR);
`else
  assign run  = 1'b1;
  assign busy = 1'b0;
`endif

  // Combinational grant; reset forces both grants low immediately
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst && run) begin
      if (req_a && (!req_b || !prio_b)) gnt_a = 1'b1;
      else if (req_b)                   gnt_b = 1'b1;
    end
  end

  // Memory command mux: granted requester, clear sweep, or idle zeros
  always_comb begin
    mem_r_w  = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (gnt_a) begin
      mem_r_w  = we_a;
      mem_addr = addr_a;
      mem_din  = wdata_a;
    end else if (gnt_b) begin
      mem_r_w  = we_b;
      mem_addr = addr_b;
      mem_din  = wdata_b;
    end
`ifdef MEM_ARBITER_CLEAR_EN
    else if (!rst && (state == CLEAR)) begin
      mem_r_w  = 1'b1;
      mem_addr = clr_cnt;
    end
`endif
  end

  // Round-robin pointer moves only when somebody is granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        prio_b <= 1'b0;
    else if (gnt_a) prio_b <= 1'b1;
    else if (gnt_b) prio_b <= 1'b0;
  end

  // Remember which requester has read data arriving next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_a <= 1'b0;
      rd_pend_b <= 1'b0;
    end else begin
      rd_pend_a <= gnt_a & ~we_a;
      rd_pend_b <= gnt_b & ~we_b;
    end
  end

  assign rvalid_a = rd_pend_a;
  assign rvalid_b = rd_pend_b;
  assign rdata_a  = mem_dout;
  assign rdata_b  = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed stimulus for mem_arbiter with a
// scoreboard; a behavioural memory sits on the memory port.
module tb_mem_arbiter;

  localparam int ADDR  = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << ADDR;
`ifdef MEM_ARBITER_CLEAR_EN
  localparam int CLEAR_CYCLES = DEPTH;
`else
  localparam int CLEAR_CYCLES = 0;
`endif

  typedef struct {
    bit            we;
    logic [ADDR-1:0] addr;
    logic [DW-1:0]   data;
  } cmd_t;

  typedef struct {
    int            cyc;
    bit            known;
    logic [DW-1:0] data;
  } rd_t;

  logic            clk;
  logic            rst;
  logic            req_a, req_b, we_a, we_b;
  logic [ADDR-1:0] addr_a, addr_b;
  logic [DW-1:0]   wdata_a, wdata_b;
  logic            gnt_a, gnt_b, rvalid_a, rvalid_b, busy, mem_r_w;
  logic [DW-1:0]   rdata_a, rdata_b, mem_din, mem_dout;
  logic [ADDR-1:0] mem_addr;

  logic [DW-1:0]   mem [DEPTH];

  cmd_t            cmdA[$];
  cmd_t            cmdB[$];
  rd_t             qa[$];
  rd_t             qb[$];

  logic [DW-1:0]   refMem [DEPTH];
  bit              refKnown [DEPTH];
  bit              lastB;
  int              clearLeft;
  int              cyc;
  int              idlePct;
  int              total;
  int              bad;

  mem_arbiter #(.ADDR(ADDR), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy),
    .mem_r_w(mem_r_w), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port synchronous memory, one cycle read latency
  always @(posedge clk) begin
    if (mem_r_w) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic checkRv(input bit side, input logic rv, input logic [DW-1:0] rd);
    rd_t h;
    bit  due;
    if (side) due = (qb.size() > 0) && (qb[0].cyc == cyc - 1);
    else      due = (qa.size() > 0) && (qa[0].cyc == cyc - 1);
    checkOutput(side ? "rvalid_b" : "rvalid_a", {63'd0, rv}, {63'd0, due});
    if (due) begin
      h = side ? qb.pop_front() : qa.pop_front();
      if (rv && h.known) checkOutput(side ? "rdata_b" : "rdata_a", {32'd0, rd}, {32'd0, h.data});
    end
  endtask

  // Monitor: reference arbitration model and read-return scoreboard
  always @(negedge clk) begin
    bit expA, expB;
    if (rst) begin
      checkOutput("rst_gnt", {62'd0, gnt_a, gnt_b}, 64'd0);
      checkOutput("rst_rvalid", {62'd0, rvalid_a, rvalid_b}, 64'd0);
      checkOutput("rst_mem_r_w", {63'd0, mem_r_w}, 64'd0);
      qa.delete();
      qb.delete();
      lastB     = 1'b1;
      clearLeft = CLEAR_CYCLES;
    end else begin
      cyc++;
      checkRv(1'b0, rvalid_a, rdata_a);
      checkRv(1'b1, rvalid_b, rdata_b);
      if (clearLeft > 0) begin
        checkOutput("clear_busy", {63'd0, busy}, 64'd1);
        checkOutput("clear_gnt", {62'd0, gnt_a, gnt_b}, 64'd0);
        checkOutput("clear_r_w", {63'd0, mem_r_w}, 64'd1);
        checkOutput("clear_addr", {60'd0, mem_addr}, 64'(DEPTH - clearLeft));
        checkOutput("clear_din", {32'd0, mem_din}, 64'd0);
        refMem[DEPTH - clearLeft]   = '0;
        refKnown[DEPTH - clearLeft] = 1'b1;
        clearLeft--;
      end else begin
        checkOutput("busy", {63'd0, busy}, 64'd0);
        expA = req_a && (!req_b || lastB);
        expB = req_b && !expA;
        checkOutput("gnt_a", {63'd0, gnt_a}, {63'd0, expA});
        checkOutput("gnt_b", {63'd0, gnt_b}, {63'd0, expB});
        if (expA || expB) begin
          cmd_t c;
          c.we   = expA ? we_a : we_b;
          c.addr = expA ? addr_a : addr_b;
          c.data = expA ? wdata_a : wdata_b;
          checkOutput("mem_r_w", {63'd0, mem_r_w}, {63'd0, c.we});
          checkOutput("mem_addr", {60'd0, mem_addr}, {60'd0, c.addr});
          if (c.we) begin
            checkOutput("mem_din", {32'd0, mem_din}, {32'd0, c.data});
            refMem[c.addr]   = c.data;
            refKnown[c.addr] = 1'b1;
          end else begin
            rd_t r;
            r.cyc   = cyc;
            r.known = refKnown[c.addr];
            r.data  = refMem[c.addr];
            if (expA) qa.push_back(r);
            else      qb.push_back(r);
          end
          lastB = expB;
        end else begin
          checkOutput("idle_port", {31'd0, mem_r_w, 28'd0, mem_addr}, 64'd0);
          checkOutput("idle_din", {32'd0, mem_din}, 64'd0);
        end
      end
    end
  end

  // Driver: hold each command until granted, then present the next one
  initial begin
    bit   ga, gb;
    cmd_t c;
    forever begin
      @(negedge clk);
      ga = gnt_a;
      gb = gnt_b;
      @(posedge clk);
      #2;
      if (rst) begin
        req_a = 1'b0;
        req_b = 1'b0;
      end else begin
        if (!req_a || ga) begin
          if (cmdA.size() > 0 && $urandom_range(99) >= idlePct) begin
            c = cmdA.pop_front();
            req_a = 1'b1; we_a = c.we; addr_a = c.addr; wdata_a = c.data;
          end else begin
            req_a = 1'b0; we_a = 1'($urandom); addr_a = ADDR'($urandom); wdata_a = $urandom;
          end
        end
        if (!req_b || gb) begin
          if (cmdB.size() > 0 && $urandom_range(99) >= idlePct) begin
            c = cmdB.pop_front();
            req_b = 1'b1; we_b = c.we; addr_b = c.addr; wdata_b = c.data;
          end else begin
            req_b = 1'b0; we_b = 1'($urandom); addr_b = ADDR'($urandom); wdata_b = $urandom;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input bit side, input bit we, input int addr, input logic [DW-1:0] data);
    cmd_t c;
    c.we   = we;
    c.addr = ADDR'(addr);
    c.data = data;
    if (side) cmdB.push_back(c);
    else      cmdA.push_back(c);
  endtask

  task automatic waitIdle(input int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      #1;
      done = (cmdA.size() == 0) && (cmdB.size() == 0) && !req_a && !req_b &&
             (qa.size() == 0) && (qb.size() == 0) && (clearLeft == 0);
    end
    checkOutput("idle_timeout", {63'd0, done}, 64'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit seen;
    total = 0; bad = 0; cyc = 0; idlePct = 0;
    lastB = 1'b1; clearLeft = CLEAR_CYCLES;
    for (int i = 0; i < DEPTH; i++) begin
      refMem[i]   = '0;
      refKnown[i] = 1'b0;
    end
    rst = 1'b1;
    req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    repeat (3) @(posedge clk);

    // B read of addr 5 presented in the very first cycle after release
    applyStimulus(1'b1, 1'b0, 5, '0);
    #1 rst = 1'b0;
    waitIdle(100);

    // A writes then reads back addr 3
    applyStimulus(1'b0, 1'b1, 3, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 3, '0);
    waitIdle(50);

    // Both hold requests: reads of addr 1 (A) and addr 2 (B) alternate
    applyStimulus(1'b0, 1'b0, 1, '0);
    applyStimulus(1'b0, 1'b0, 1, '0);
    applyStimulus(1'b1, 1'b0, 2, '0);
    applyStimulus(1'b1, 1'b0, 2, '0);
    waitIdle(50);

    // Same cycle A write / B read of addr 7
    applyStimulus(1'b0, 1'b1, 7, 32'h11);
    applyStimulus(1'b1, 1'b0, 7, '0);
    waitIdle(50);

    // Reset right after a read grant to B aborts the read
    applyStimulus(1'b1, 1'b0, 2, '0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = gnt_b;
    end
    checkOutput("gnt_b_before_rst", {63'd0, seen}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    cmdA.delete();
    cmdB.delete();
    repeat (2) @(posedge clk);
    applyStimulus(1'b0, 1'b0, 4, '0);
    applyStimulus(1'b1, 1'b0, 6, '0);
    #1 rst = 1'b0;
    waitIdle(100);

    // Randomized traffic
    idlePct = 30;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 1'($urandom), $urandom_range(DEPTH - 1), $urandom);
      applyStimulus(1'b1, 1'($urandom), $urandom_range(DEPTH - 1), $urandom);
    end
    waitIdle(3000);

    checkOutput("final_queues", 64'(qa.size() + qb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
